// File: rtl/ram_byte_reader_if.sv
// ----------------------------------------------------------------------------
// ram_byte_reader_if
//   Byte-stream handshake bundle produced by ram_byte_reader.
//   Signals:
//     m_data   [7:0]  stream byte
//     m_valid         m_data is valid
//     m_ready         sink accepts the byte when m_valid && m_ready
//     m_last          marks the final byte of a run
//   Modports:
//     master  drives m_data/m_valid/m_last, samples m_ready
//     slave   the opposite direction (byte sink)
// ----------------------------------------------------------------------------
interface ram_byte_reader_if;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/ram_byte_reader.sv
// ----------------------------------------------------------------------------
// ram_byte_reader
//   Read-side master for the byte-enable RAM. Fetches a run of words over the
//   RAM read port and unpacks them into a byte stream, starting at an
//   arbitrary byte lane of the base word. Lane 0 (bits 7:0) is emitted first.
//
//   Ports:
//     clk         clock, rising edge
//     rst_n       asynchronous reset, active-low
//     start       one-cycle request, sampled only when idle
//     base_addr   word address of the first byte
//     start_lane  lane of the first byte within the base word
//     len_bytes   number of bytes to stream (0 = empty run, just a done pulse)
//     ram_addr    RAM read address
//     ram_data    RAM registered read data
//     m           byte stream (ram_byte_reader_if.master)
//     busy        high whenever the FSM is not idle
//     done        one-cycle pulse when a run completes
//
//   Configuration macro:
//     RAM_OUT_REG_EN  RAM has an extra output register (2-cycle read); a
//                     WAIT_RD state is inserted between FETCH and CAPT.
// ----------------------------------------------------------------------------
module ram_byte_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 9,
  localparam int NL        = DATA_WIDTH / 8,
  localparam int LANE_W    = (NL > 1) ? $clog2(NL) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LANE_W-1:0]     start_lane,
  input  logic [LEN_WIDTH-1:0]  len_bytes,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  ram_byte_reader_if.master     m,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    CAPT,
    STREAM,
    DONE
  } state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NL - 1);

  state_t                state;
  logic [LANE_W-1:0]     lane;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [DATA_WIDTH-1:0] word_reg;

  logic [LANE_W-1:0]     lane_next;
  logic [7:0]            capt_byte;
  logic [7:0]            next_byte;

  always_comb begin
    lane_next = lane + LANE_W'(1);
    // First byte of a freshly fetched word comes straight off the RAM port,
    // so m_data is ready in the same cycle word_reg is loaded.
    capt_byte = ram_data[8*lane +: 8];
    next_byte = word_reg[8*lane_next +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register here is state updated on the clock edge, so all
      // assignments are non-blocking; blocking ones would let later
      // statements see half-updated values and break simulation/synthesis
      // equivalence.
      state     <= IDLE;
      lane      <= '0;
      remaining <= '0;
      word_reg  <= '0;
      ram_addr  <= '0;
      m.m_data  <= '0;
      m.m_valid <= 1'b0;
      m.m_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ram_addr  <= base_addr;
            lane      <= start_lane;
            remaining <= len_bytes;
            busy      <= 1'b1;
            if (len_bytes == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end

        // ram_addr is held for this cycle so the RAM registers it.
        FETCH: begin
`ifdef RAM_OUT_REG_EN
          state <= WAIT_RD;
`else
          state <= CAPT;
`endif
        end

        // Second cycle of a read through the RAM output register.
        WAIT_RD: state <= CAPT;

        CAPT: begin
          word_reg  <= ram_data;
          m.m_data  <= capt_byte;
          m.m_valid <= 1'b1;
          m.m_last  <= (remaining == LEN_WIDTH'(1));
          state     <= STREAM;
        end

        // Outputs only move on a handshake, so m_data/m_last stay put while
        // the sink stalls and m_valid never drops without acceptance.
        STREAM: begin
          if (m.m_ready) begin
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              m.m_valid <= 1'b0;
              m.m_last  <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else if (lane == LAST_LANE) begin
              // Word exhausted: move to the next word; address wraps freely.
              lane      <= '0;
              ram_addr  <= ram_addr + ADDR_WIDTH'(1);
              m.m_valid <= 1'b0;
              m.m_last  <= 1'b0;
              state     <= FETCH;
            end else begin
              lane     <= lane_next;
              m.m_data <= next_byte;
              m.m_last <= (remaining == LEN_WIDTH'(2));
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_byte_reader.sv
// ----------------------------------------------------------------------------
// tb_ram_byte_reader
//   Directed bench for ram_byte_reader with a behavioural registered-read RAM.
//   Expected bytes and word addresses are derived from a reference table of
//   the preloaded RAM contents and queued before each run; the stream is
//   popped and compared as bytes are accepted.
// ----------------------------------------------------------------------------
module tb_ram_byte_reader;

`ifdef RAM_OUT_REG_EN
  localparam int FIRST_LAT = 4;
  localparam int REFETCH   = 3;
`else
  localparam int FIRST_LAT = 3;
  localparam int REFETCH   = 2;
`endif
  localparam int BUDGET = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [0:0]  start_lane;
  logic [8:0]  len_bytes;
  logic [7:0]  ram_addr;
  logic [15:0] ram_data;
  logic        busy;
  logic        done;

  ram_byte_reader_if bus ();

  ram_byte_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .start_lane (start_lane),
    .len_bytes  (len_bytes),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .m          (bus),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, registered read (optionally two stages).
  logic [15:0] mem [256];
  logic [15:0] rd_q;
  always @(posedge clk) rd_q <= mem[ram_addr];
`ifdef RAM_OUT_REG_EN
  logic [15:0] rd_q2;
  always @(posedge clk) rd_q2 <= rd_q;
  assign ram_data = rd_q2;
`else
  assign ram_data = rd_q;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] exp_addr_q[$];
  logic [7:0] seen_addr_q[$];

  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] ref_word(input logic [7:0] a);
    case (a)
      8'd0:    return 16'h1234;
      8'd1:    return 16'h00F8;
      8'd3:    return 16'h02CC;
      8'd255:  return 16'hBEEF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [7:0] base, input int lane, input int len);
    logic [15:0] w;
    logic [7:0]  a;
    beat_t       b;
    for (int i = 0; i < len; i++) begin
      a = 8'(int'(base) + (lane + i) / 2);
      w = ref_word(a);
      b.data = w[8*((lane + i) % 2) +: 8];
      b.last = (i == len - 1);
      exp_q.push_back(b);
      if (i == 0 || ((lane + i) % 2) == 0) exp_addr_q.push_back(a);
    end
  endtask

  // One complete run: queue expectations, pulse start, then consume the
  // stream with an optional stall on the first byte (and an optional stray
  // start during that stall, which must be ignored).
  task automatic run(input string tag, input logic [7:0] base, input logic [0:0] lane,
                     input logic [8:0] len, input int stall, input bit poke,
                     input int exp_done_k);
    int    k = 0;
    int    first_k = -1;
    int    last_hs_k = -1;
    int    done_k = -1;
    int    stall_left = stall;
    bit    holding = 1'b0;
    beat_t held;
    beat_t e;
    exp_q.delete();
    exp_addr_q.delete();
    seen_addr_q.delete();
    push_expected(base, int'(lane), int'(len));

    @(negedge clk);
    base_addr  = base;
    start_lane = lane;
    len_bytes  = len;
    start      = 1'b1;
    bus.m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble inputs: the run must not re-sample them.
    base_addr  = 8'hAA;
    start_lane = 1'b0;
    len_bytes  = 9'd7;
    k = 1;

    while (done_k < 0 && k < BUDGET) begin
      if (busy && (seen_addr_q.size() == 0 || seen_addr_q[$] != ram_addr))
        seen_addr_q.push_back(ram_addr);
      if (done) begin
        done_k = k;
        check({tag, " busy during done"}, 32'(busy), 32'd1);
      end
      if (bus.m_valid) begin
        if (first_k < 0) first_k = k;
        if (holding) begin
          check({tag, " held data"}, 32'(bus.m_data), 32'(held.data));
          check({tag, " held last"}, 32'(bus.m_last), 32'(held.last));
        end
        if (stall_left > 0) begin
          bus.m_ready = 1'b0;
          held.data = bus.m_data;
          held.last = bus.m_last;
          holding = 1'b1;
          stall_left--;
          if (poke) begin
            start     = 1'b1;
            base_addr = 8'd0;
            len_bytes = 9'd4;
          end
        end else begin
          bus.m_ready = 1'b1;
          holding = 1'b0;
          if (exp_q.size() == 0) begin
            check({tag, " extra byte"}, 32'(bus.m_data), 32'h1FF);
          end else begin
            e = exp_q.pop_front();
            check({tag, " byte"}, 32'(bus.m_data), 32'(e.data));
            check({tag, " last"}, 32'(bus.m_last), 32'(e.last));
          end
          last_hs_k = k + 1;
        end
      end else begin
        if (holding) check({tag, " valid dropped"}, 32'd0, 32'd1);
        bus.m_ready = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      k++;
    end

    check({tag, " done seen"}, 32'(done_k >= 0), 32'd1);
    check({tag, " bytes missing"}, 32'(exp_q.size()), 32'd0);
    check({tag, " done cycle"}, 32'(done_k), 32'(exp_done_k));
    if (len != 9'd0) begin
      check({tag, " first valid latency"}, 32'(first_k), 32'(FIRST_LAT));
      check({tag, " done after last"}, 32'(done_k), 32'(last_hs_k));
      check({tag, " addr count"}, 32'(seen_addr_q.size()), 32'(exp_addr_q.size()));
      for (int i = 0; i < exp_addr_q.size() && i < seen_addr_q.size(); i++)
        check({tag, " addr"}, 32'(seen_addr_q[i]), 32'(exp_addr_q[i]));
    end else begin
      check({tag, " no valid"}, 32'(first_k), 32'hFFFF_FFFF);
    end
    // The cycle after done: back to idle and quiet.
    check({tag, " done pulse width"}, 32'(done), 32'd0);
    check({tag, " busy fell"}, 32'(busy), 32'd0);
    check({tag, " valid idle"}, 32'(bus.m_valid), 32'd0);
  endtask

  initial begin
    int vcount;
    int k;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h1234;
    mem[1]   = 16'h00F8;
    mem[3]   = 16'h02CC;
    mem[255] = 16'hBEEF;

    rst_n       = 1'b0;
    start       = 1'b0;
    base_addr   = '0;
    start_lane  = '0;
    len_bytes   = '0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("reset ram_addr", 32'(ram_addr), 32'd0);
    check("reset m_data", 32'(bus.m_data), 32'd0);
    check("reset m_valid", 32'(bus.m_valid), 32'd0);
    check("reset m_last", 32'(bus.m_last), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Two bytes from one word.
    run("c1", 8'd3, 1'b0, 9'd2, 0, 1'b0, FIRST_LAT + 2);
    // Single byte from the upper lane, address stays put.
    run("c2", 8'd1, 1'b1, 9'd1, 0, 1'b0, FIRST_LAT + 1);
    // Run crossing the address wrap 255 -> 0.
    run("c3", 8'd255, 1'b0, 9'd4, 0, 1'b0, FIRST_LAT + 2 + REFETCH + 2);
    // Sink stalls 3 cycles on the first byte; stray start during the stall.
    run("c4", 8'd3, 1'b0, 9'd2, 3, 1'b1, FIRST_LAT + 2 + 3);
    // Empty run: only a done pulse.
    run("c5", 8'd3, 1'b0, 9'd0, 0, 1'b0, 1);

    // start while busy (in DONE) is ignored.
    @(negedge clk);
    base_addr = 8'd3; start_lane = 1'b0; len_bytes = 9'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c5b done", 32'(done), 32'd1);
    len_bytes = 9'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c5b busy after ignored start", 32'(busy), 32'd0);
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.m_valid || busy) vcount++;
    end
    check("c5b ignored start activity", 32'(vcount), 32'd0);

    // Asynchronous reset in the middle of streaming.
    @(negedge clk);
    base_addr = 8'd255; start_lane = 1'b0; len_bytes = 9'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!bus.m_valid && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("c6 streaming before reset", 32'(bus.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("c6 async ram_addr", 32'(ram_addr), 32'd0);
    check("c6 async m_data", 32'(bus.m_data), 32'd0);
    check("c6 async m_valid", 32'(bus.m_valid), 32'd0);
    check("c6 async m_last", 32'(bus.m_last), 32'd0);
    check("c6 async busy", 32'(busy), 32'd0);
    check("c6 async done", 32'(done), 32'd0);
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy || bus.m_valid) vcount++;
    end
    check("c6 quiet in reset", 32'(vcount), 32'd0);
    rst_n = 1'b1;
    run("c6 rerun", 8'd255, 1'b0, 9'd4, 0, 1'b0, FIRST_LAT + 2 + REFETCH + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
